// File: rtl/rest_serial8b_if.sv
// Handshake/operand bundle for the bit-serial subtractor rest_serial8b.
// The o_Overflow signal exists only when RESTA_OVF_EN is defined.
interface rest_serial8b_if #(
  parameter int WIDTH = 8
);
  logic             i_Start;
  logic [WIDTH-1:0] i_bit1;
  logic [WIDTH-1:0] i_bit2;
  logic             i_Borrow;
  logic             o_Busy;
  logic             o_Valid;
  logic [WIDTH-1:0] o_Resta;
  logic             o_Borrow;
`ifdef RESTA_OVF_EN
  logic             o_Overflow;
`endif

  modport master (
    output i_Start, i_bit1, i_bit2, i_Borrow,
`ifdef RESTA_OVF_EN
    input  o_Overflow,
`endif
    input  o_Busy, o_Valid, o_Resta, o_Borrow
  );

  modport slave (
    input  i_Start, i_bit1, i_bit2, i_Borrow,
`ifdef RESTA_OVF_EN
    output o_Overflow,
`endif
    output o_Busy, o_Valid, o_Resta, o_Borrow
  );
endinterface

// File: rtl/rest_serial8b.sv
// Bit-serial subtractor computing A - B - Bin LSB first, one bit per clock.
// Optional signed-overflow output o_Overflow is enabled by macro RESTA_OVF_EN.
module rest_serial8b #(
  parameter int WIDTH = 8
) (
  input  logic           i_Clk,
  input  logic           i_Reset,
  rest_serial8b_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [CNT_W-1:0] cnt_q;
  logic             br_q;
  logic             busy_q;
  logic             valid_q;
  logic [WIDTH-1:0] resta_q;
  logic             borrow_q;
  logic             diff_d;
  logic             br_d;
  logic [WIDTH-1:0] res_d;

  // Full-subtractor cell on the current LSBs and running borrow.
  always_comb begin
    diff_d = a_q[0] ^ b_q[0] ^ br_q;
    br_d   = (~a_q[0] & b_q[0]) | (~a_q[0] & br_q) | (b_q[0] & br_q);
    res_d  = {diff_d, res_q[WIDTH-1:1]};
  end

`ifdef RESTA_OVF_EN
  logic a_msb_q;
  logic b_msb_q;
  logic ovf_q;

  // Operand sign bits are captured at acceptance; overflow is resolved with the result.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (state_q == S_IDLE && bus.i_Start) begin
      a_msb_q <= bus.i_bit1[WIDTH-1];
      b_msb_q <= bus.i_bit2[WIDTH-1];
    end else if (state_q == S_SHIFT && cnt_q == CNT_W'(WIDTH-1)) begin
      ovf_q <= (a_msb_q != b_msb_q) && (diff_d != a_msb_q);
    end
  end

  assign bus.o_Overflow = ovf_q;
`endif

  // Sequencer with registered handshake and result outputs.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      resta_q  <= '0;
      borrow_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          valid_q <= 1'b0;
          if (bus.i_Start) begin
            a_q     <= bus.i_bit1;
            b_q     <= bus.i_bit2;
            br_q    <= bus.i_Borrow;
            res_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          res_q <= res_d;
          br_q  <= br_d;
          if (cnt_q == CNT_W'(WIDTH-1)) begin
            // Publish on the final bit so the result is visible throughout DONE.
            resta_q  <= res_d;
            borrow_q <= br_d;
            valid_q  <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DONE: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_Busy   = busy_q;
  assign bus.o_Valid  = valid_q;
  assign bus.o_Resta  = resta_q;
  assign bus.o_Borrow = borrow_q;
endmodule

// File: tb/tb_rest_serial8b.sv
// Randomized and directed bench for rest_serial8b against an arithmetic model.
// Define RESTA_OVF_EN consistently with the RTL build to check o_Overflow too.
module tb_rest_serial8b;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_total = 0;
  int   n_pass  = 0;

  rest_serial8b_if #(.WIDTH(WIDTH)) bus ();

  rest_serial8b #(.WIDTH(WIDTH)) dut (
    .i_Clk   (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_idle_zero(input string tag);
    check_eq({tag, "_busy"},   32'(bus.o_Busy),   32'd0);
    check_eq({tag, "_valid"},  32'(bus.o_Valid),  32'd0);
    check_eq({tag, "_resta"},  32'(bus.o_Resta),  32'd0);
    check_eq({tag, "_borrow"}, 32'(bus.o_Borrow), 32'd0);
`ifdef RESTA_OVF_EN
    check_eq({tag, "_ovf"},    32'(bus.o_Overflow), 32'd0);
`endif
  endtask

  // One full operation; inj>0 drives a stray start (A=B=1) in that busy cycle.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bin, input int inj);
    logic [8:0] wide;
    logic [7:0] er;
    logic       eb;
    logic       eo;
    int         busy_n;
    int         valid_n;
    int         cyc;
    wide = {1'b0, a} - {1'b0, b} - {8'd0, bin};
    er   = wide[7:0];
    eb   = (int'(a) < int'(b) + int'(bin));
    eo   = (a[7] != b[7]) && (er[7] != a[7]);
    @(negedge clk);
    bus.i_bit1   = a;
    bus.i_bit2   = b;
    bus.i_Borrow = bin;
    bus.i_Start  = 1'b1;
    @(negedge clk);
    bus.i_Start  = 1'b0;
    bus.i_bit1   = 8'($urandom);
    bus.i_bit2   = 8'($urandom);
    bus.i_Borrow = 1'($urandom);
    busy_n  = 0;
    valid_n = 0;
    cyc     = 0;
    while (cyc < 40 && !(bus.o_Busy == 1'b0 && busy_n > 0)) begin
      if (bus.o_Busy) busy_n++;
      if (inj > 0 && busy_n == inj) begin
        bus.i_Start = 1'b1;
        bus.i_bit1  = 8'd1;
        bus.i_bit2  = 8'd1;
      end else begin
        bus.i_Start = 1'b0;
      end
      if (bus.o_Valid) begin
        valid_n++;
        check_eq("resta",        32'(bus.o_Resta),  32'(er));
        check_eq("borrow",       32'(bus.o_Borrow), 32'(eb));
        check_eq("valid_in_last_busy", 32'(busy_n), 32'(WIDTH + 1));
`ifdef RESTA_OVF_EN
        check_eq("overflow",     32'(bus.o_Overflow), 32'(eo));
`endif
      end
      @(negedge clk);
      cyc++;
    end
    bus.i_Start = 1'b0;
    check_eq("busy_cycles",  32'(busy_n),  32'(WIDTH + 1));
    check_eq("valid_pulses", 32'(valid_n), 32'd1);
    @(negedge clk);
    check_eq("resta_hold",  32'(bus.o_Resta),  32'(er));
    check_eq("borrow_hold", 32'(bus.o_Borrow), 32'(eb));
    check_eq("idle_valid",  32'(bus.o_Valid),  32'd0);
  endtask

  initial begin
    int vseen;
    bus.i_Start  = 1'b0;
    bus.i_bit1   = '0;
    bus.i_bit2   = '0;
    bus.i_Borrow = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_idle_zero("reset");

    run_op(8'd50,  8'd20,  1'b0, 0);
    run_op(8'd10,  8'd250, 1'b0, 0);
    run_op(8'd0,   8'd255, 1'b1, 0);
    run_op(8'd255, 8'd255, 1'b0, 0);
    run_op(8'd128, 8'd1,   1'b0, 0);
    run_op(8'd127, 8'd255, 1'b1, 0);
    run_op(8'd100, 8'd30,  1'b0, 3);

    // Abort mid-operation with a one-cycle reset.
    @(negedge clk);
    bus.i_bit1  = 8'd200;
    bus.i_bit2  = 8'd50;
    bus.i_Start = 1'b1;
    @(negedge clk);
    bus.i_Start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_zero("abort");
    vseen = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.o_Valid || bus.o_Busy) vseen++;
      @(negedge clk);
    end
    check_eq("abort_no_activity", 32'(vseen), 32'd0);
    run_op(8'd9, 8'd3, 1'b0, 0);

    for (int k = 0; k < 25; k++) begin
      run_op(8'($urandom), 8'($urandom), 1'($urandom), (k % 4 == 0) ? int'($urandom_range(1, 9)) : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
